controle_jogo: RTL and testbench

Breakout game-flow controller that sequences the scoreboard, ball and block logic.
- Tracks game phase (idle, serve, play, pause, life lost, level clear, game over), lives, remaining blocks and level.
- Drives the scoreboard `start` level and one-cycle event pulses (hit, life lost, block at floor).
- Enables or holds the ball engine.
- Sits between the debounced buttons and the physics blocks on one side, and the scoreboard on the other.

---
 rtl/controle_jogo_pkg.sv | 21 ++
 rtl/controle_jogo_tick_gen.sv | 20 ++
 rtl/controle_jogo.sv | 162 ++++++++++++++++
 tb/tb_controle_jogo.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/controle_jogo_pkg.sv
// controle_jogo_pkg: phase encodings, output widths and default timing for the breakout flow controller.
package controle_jogo_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    LOST  = 3'd4,
    CLEAR = 3'd5,
    OVER  = 3'd6
  } fase_e;
  localparam int LIVES_W  = 6;
  localparam int BLOCKS_W = 8;
  localparam int LEVEL_W  = 4;
  localparam int DEF_TICK_DIV     = 833333;
  localparam int DEF_SERVE_TICKS  = 120;
  localparam int DEF_FREEZE_TICKS = 90;
  localparam int DEF_N_BLOCKS     = 40;
  localparam int DEF_LIVES        = 3;
  localparam logic [LEVEL_W-1:0] MAX_LEVEL = 4'd15;
endpackage

// File: rtl/controle_jogo_tick_gen.sv
// controle_jogo_tick_gen: one-cycle tick every TICK_DIV clocks, frozen while hold is high.
module controle_jogo_tick_gen import controle_jogo_pkg::*; #(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = !hold && cnt_q == W'(TICK_DIV - 1);
    cnt_d = hold ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/controle_jogo.sv
// controle_jogo: breakout game-flow FSM driving scoreboard, ball engine and block counters.
// Define PAUSE_EN to enable the PAUSE state and the btn_pause input.
module controle_jogo import controle_jogo_pkg::*; #(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int SERVE_TICKS  = DEF_SERVE_TICKS,
  parameter int FREEZE_TICKS = DEF_FREEZE_TICKS,
  parameter int N_BLOCKS     = DEF_N_BLOCKS,
  parameter int LIVES        = DEF_LIVES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                btn_start,
  input  logic                btn_pause,
  input  logic                ball_lost,
  input  logic                block_hit,
  input  logic                block_floor,
  output logic                start,
  output logic                hit_pulse,
  output logic                lost_pulse,
  output logic                floor_pulse,
  output logic                ball_reset,
  output logic                ball_run,
  output logic [LIVES_W-1:0]  lives_left,
  output logic [BLOCKS_W-1:0] blocks_left,
  output logic [LEVEL_W-1:0]  level,
  output logic [2:0]          fase
);
`ifdef PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif
  localparam int CD_MAX = SERVE_TICKS > FREEZE_TICKS ? SERVE_TICKS : FREEZE_TICKS;
  localparam int CD_W = $clog2(CD_MAX + 2);
  localparam logic [CD_W-1:0]     CD_SERVE  = CD_W'(SERVE_TICKS);
  localparam logic [CD_W-1:0]     CD_FREEZE = CD_W'(FREEZE_TICKS);
  localparam logic [LIVES_W-1:0]  L0 = LIVES_W'(LIVES);
  localparam logic [BLOCKS_W-1:0] B0 = BLOCKS_W'(N_BLOCKS);
  fase_e st_q, st_d;
  logic [CD_W-1:0] cd_q, cd_d, cd_dec;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [BLOCKS_W-1:0] blocks_q, blocks_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic hit_q, hit_d, lost_q, lost_d, floor_q, floor_d;
  logic [4:0] in_q, in_now, edg;
  logic start_e, pause_e, lost_e, hit_e, floor_e, tick, hold, cd_done;
  controle_jogo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .hold  (hold),
    .tick  (tick)
  );
  always_comb begin
    in_now  = {btn_start, btn_pause, ball_lost, block_hit, block_floor};
    edg     = in_now & ~in_q;
    start_e = edg[4];
    pause_e = PAUSE_ON & edg[3];
    lost_e  = edg[2];
    hit_e   = edg[1];
    floor_e = edg[0];
    hold    = PAUSE_ON && st_q == PAUSE;
    cd_dec  = (tick && cd_q != '0) ? cd_q - 1'b1 : cd_q;
    cd_done = cd_q == '0 || (tick && cd_q == CD_W'(1));
  end
  always_comb begin
    st_d     = st_q;
    cd_d     = cd_q;
    lives_d  = lives_q;
    blocks_d = blocks_q;
    level_d  = level_q;
    hit_d    = 1'b0;
    lost_d   = 1'b0;
    floor_d  = 1'b0;
    case (st_q)
      IDLE: if (start_e) begin
        st_d     = SERVE;
        lives_d  = L0;
        blocks_d = B0;
        level_d  = LEVEL_W'(1);
        cd_d     = CD_SERVE;
      end
      SERVE: begin
        cd_d = cd_dec;
        if (cd_done || start_e) st_d = PLAY;
      end
      PLAY: if (floor_e) begin
        floor_d = 1'b1;
        st_d    = OVER;
      end else begin
        if (hit_e && blocks_q != '0) begin
          blocks_d = blocks_q - 1'b1;
          hit_d    = 1'b1;
        end
        if (lost_e && lives_q != '0) begin
          lives_d = lives_q - 1'b1;
          lost_d  = 1'b1;
        end
        // a loss outranks a simultaneous clear
        if (lost_d) begin
          st_d = lives_d == '0 ? OVER : LOST;
          cd_d = CD_FREEZE;
        end else if (blocks_d == '0) begin
          st_d = CLEAR;
          cd_d = CD_FREEZE;
        end else if (pause_e) st_d = PAUSE;
      end
      PAUSE: if (pause_e) st_d = PLAY;
      LOST: begin
        cd_d = cd_dec;
        if (cd_done) begin
          st_d = SERVE;
          cd_d = CD_SERVE;
        end
      end
      CLEAR: begin
        cd_d = cd_dec;
        if (cd_done) begin
          st_d     = SERVE;
          cd_d     = CD_SERVE;
          blocks_d = B0;
          level_d  = level_q == MAX_LEVEL ? level_q : level_q + 1'b1;
        end
      end
      OVER: if (start_e) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    in_q <= in_now;
    if (!reset) begin
      st_q     <= IDLE;
      cd_q     <= '0;
      lives_q  <= L0;
      blocks_q <= B0;
      level_q  <= LEVEL_W'(1);
      hit_q    <= 1'b0;
      lost_q   <= 1'b0;
      floor_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      cd_q     <= cd_d;
      lives_q  <= lives_d;
      blocks_q <= blocks_d;
      level_q  <= level_d;
      hit_q    <= hit_d;
      lost_q   <= lost_d;
      floor_q  <= floor_d;
    end
  end
  always_comb begin
    start       = st_q == SERVE || st_q == PLAY || st_q == PAUSE;
    ball_run    = st_q == PLAY;
    ball_reset  = st_q == IDLE || st_q == SERVE || st_q == LOST || st_q == CLEAR;
    hit_pulse   = hit_q;
    lost_pulse  = lost_q;
    floor_pulse = floor_q;
    lives_left  = lives_q;
    blocks_left = blocks_q;
    level       = level_q;
    fase        = st_q;
  end
endmodule

// File: tb/tb_controle_jogo.sv
// tb_controle_jogo: directed checks of game flow with TICK_DIV=4, SERVE=3, FREEZE=2, N_BLOCKS=3, LIVES=2.
module tb_controle_jogo;
  logic clock = 1'b0, reset = 1'b0;
  logic btn_start = 1'b0, btn_pause = 1'b0, ball_lost = 1'b0, block_hit = 1'b0, block_floor = 1'b0;
  logic start, hit_pulse, lost_pulse, floor_pulse, ball_reset, ball_run;
  logic [5:0] lives_left;
  logic [7:0] blocks_left;
  logic [3:0] level;
  logic [2:0] fase;
  int n_chk = 0, n_pass = 0, n_fail = 0, n = 0;
  controle_jogo #(
    .TICK_DIV(4), .SERVE_TICKS(3), .FREEZE_TICKS(2), .N_BLOCKS(3), .LIVES(2)
  ) dut (
    .clock(clock), .reset(reset), .btn_start(btn_start), .btn_pause(btn_pause),
    .ball_lost(ball_lost), .block_hit(block_hit), .block_floor(block_floor),
    .start(start), .hit_pulse(hit_pulse), .lost_pulse(lost_pulse), .floor_pulse(floor_pulse),
    .ball_reset(ball_reset), .ball_run(ball_run), .lives_left(lives_left),
    .blocks_left(blocks_left), .level(level), .fase(fase)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_fase(input logic [2:0] f, input int lim, input string tag, output int cnt);
    cnt = 0;
    while (fase !== f && cnt < lim) begin
      step();
      cnt++;
    end
    chk(tag, 32'(fase), 32'(f));
  endtask
  task automatic launch();
    btn_start = 1'b1;
    step();
    chk("launch_fase", 32'(fase), 2);
    btn_start = 1'b0;
    step();
  endtask
  initial begin
    repeat (3) step();
    chk("rst_fase", 32'(fase), 0);
    chk("rst_lives", 32'(lives_left), 2);
    chk("rst_blocks", 32'(blocks_left), 3);
    chk("rst_level", 32'(level), 1);
    chk("rst_start", 32'(start), 0);
    chk("rst_ball_reset", 32'(ball_reset), 1);
    chk("rst_ball_run", 32'(ball_run), 0);
    reset = 1'b1;
    btn_start = 1'b1;
    step();
    chk("serve_fase", 32'(fase), 1);
    chk("serve_start", 32'(start), 1);
    btn_start = 1'b0;
    wait_fase(3'd2, 20, "auto_launch", n);
    chk("serve_len", 32'(n), 11);
    chk("play_ball_run", 32'(ball_run), 1);
    chk("play_ball_reset", 32'(ball_reset), 0);
    for (int i = 0; i < 3; i++) begin
      block_hit = 1'b1;
      step();
      chk("hit_pulse", 32'(hit_pulse), 1);
      chk("hit_blocks", 32'(blocks_left), 32'(2 - i));
      chk("hit_fase", 32'(fase), i == 2 ? 5 : 2);
      block_hit = 1'b0;
      step();
      chk("hit_pulse_low", 32'(hit_pulse), 0);
    end
    chk("clear_start", 32'(start), 0);
    wait_fase(3'd1, 20, "clear_to_serve", n);
    chk("clear_level", 32'(level), 2);
    chk("clear_blocks", 32'(blocks_left), 3);
    launch();
    ball_lost = 1'b1;
    step();
    chk("lost_pulse", 32'(lost_pulse), 1);
    chk("lost_lives", 32'(lives_left), 1);
    chk("lost_fase", 32'(fase), 4);
    chk("lost_start", 32'(start), 0);
    ball_lost = 1'b0;
    step();
    chk("lost_pulse_low", 32'(lost_pulse), 0);
    wait_fase(3'd1, 20, "lost_to_serve", n);
    chk("serve_lives", 32'(lives_left), 1);
    launch();
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
`ifdef PAUSE_EN
    chk("pause_fase", 32'(fase), 3);
    chk("pause_ball_run", 32'(ball_run), 0);
    step();
    block_hit = 1'b1;
    step();
    chk("pause_hit_pulse", 32'(hit_pulse), 0);
    chk("pause_blocks", 32'(blocks_left), 3);
    chk("pause_hold", 32'(fase), 3);
    block_hit = 1'b0;
    btn_pause = 1'b1;
    step();
    chk("resume_fase", 32'(fase), 2);
    btn_pause = 1'b0;
    step();
`else
    chk("nopause_fase", 32'(fase), 2);
    step();
`endif
    ball_lost = 1'b1;
    step();
    chk("over_lost_pulse", 32'(lost_pulse), 1);
    chk("over_lives", 32'(lives_left), 0);
    chk("over_fase", 32'(fase), 6);
    ball_lost = 1'b0;
    step();
    chk("over_level_hold", 32'(level), 2);
    btn_start = 1'b1;
    step();
    chk("over_to_idle", 32'(fase), 0);
    chk("idle_lives_hold", 32'(lives_left), 0);
    btn_start = 1'b0;
    step();
    btn_start = 1'b1;
    step();
    chk("new_fase", 32'(fase), 1);
    chk("new_lives", 32'(lives_left), 2);
    chk("new_blocks", 32'(blocks_left), 3);
    chk("new_level", 32'(level), 1);
    btn_start = 1'b0;
    step();
    launch();
    for (int j = 0; j < 2; j++) begin
      block_hit = 1'b1;
      step();
      block_hit = 1'b0;
      step();
    end
    chk("pre_sim_blocks", 32'(blocks_left), 1);
    block_hit = 1'b1;
    ball_lost = 1'b1;
    step();
    chk("sim_hit_pulse", 32'(hit_pulse), 1);
    chk("sim_lost_pulse", 32'(lost_pulse), 1);
    chk("sim_blocks", 32'(blocks_left), 0);
    chk("sim_lives", 32'(lives_left), 1);
    chk("sim_fase", 32'(fase), 4);
    block_hit = 1'b0;
    ball_lost = 1'b0;
    step();
    wait_fase(3'd1, 20, "sim_to_serve", n);
    reset = 1'b0;
    step();
    reset = 1'b1;
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
    launch();
    block_hit = 1'b1;
    step();
    block_hit = 1'b0;
    chk("mid_hit_blocks", 32'(blocks_left), 2);
    reset = 1'b0;
    step();
    chk("mid_rst_fase", 32'(fase), 0);
    chk("mid_rst_lives", 32'(lives_left), 2);
    chk("mid_rst_blocks", 32'(blocks_left), 3);
    chk("mid_rst_level", 32'(level), 1);
    chk("mid_rst_start", 32'(start), 0);
    reset = 1'b1;
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
    launch();
    block_floor = 1'b1;
    block_hit = 1'b1;
    step();
    chk("floor_pulse", 32'(floor_pulse), 1);
    chk("floor_hit_pulse", 32'(hit_pulse), 0);
    chk("floor_blocks", 32'(blocks_left), 3);
    chk("floor_fase", 32'(fase), 6);
    block_floor = 1'b0;
    block_hit = 1'b0;
    step();
    chk("floor_pulse_low", 32'(floor_pulse), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
